// File: rtl/dmem_resp.sv
// dmem_resp -- data-memory responder between EX and WB.
//
// Services one load or store at a time against a word-wide synchronous RAM
// with no byte enables. Byte and halfword stores read the word, merge the
// selected lane and write the result back. Loads return sign- or
// zero-extended data with a one-cycle response pulse. Illegal accesses are
// answered with rsp_err and never touch the RAM.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   request accepted this cycle if req_valid is high (IDLE only)
//   mem_rena   in   1   request is a load
//   mem_wena   in   1   request is a store
//   addr       in   32  byte address
//   funct3     in   3   access width: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   wdata      in   32  store data; low byte/half used for SB/SH
//   rsp_valid  out  1   one-cycle response pulse
//   rdata      out  32  extended load data while rsp_valid, otherwise 0
//   rsp_err    out  1   access fault flag while rsp_valid, otherwise 0
//
// Latency from the accepting edge to the response cycle:
//   fault 1 cycle, load/SW 2 cycles, SB/SH 3 cycles.

module dmem_resp #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_rena,
    input  logic        mem_wena,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RMW_WR,
        RESP,
        ERR
    } state_t;

    state_t state;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       ram_q;
    logic              ram_re;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [ADDR_W-1:0] word_idx;

    logic [ADDR_W+1:0] addr_p0;
    logic [31:0]       wdata_p0;
    logic [2:0]        f3_p0;
    logic              load_p0;

    logic              accept;
    logic              fault;

    // Any reason a request must be answered with an error instead of a RAM
    // access: ambiguous kind, width not legal for the kind, misalignment, or
    // an address beyond the RAM.
    function automatic logic is_fault(input logic        rena,
                                      input logic        wena,
                                      input logic [31:0] a,
                                      input logic [2:0]  f3);
        logic bad;
        bad = (rena == wena);
        if (rena && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
            bad = 1'b1;
        if (wena && !(f3 inside {3'b000, 3'b001, 3'b010}))
            bad = 1'b1;
        if ((f3[1:0] == 2'b01) && a[0])
            bad = 1'b1;
        if ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00))
            bad = 1'b1;
        if ((a >> (ADDR_W + 2)) != 32'd0)
            bad = 1'b1;
        return bad;
    endfunction

    // Select the addressed lane and extend it to 32 bits. Halfword accesses
    // are aligned, so a byte-granular shift also selects the right half.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [31:0]        shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        shifted = word >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = shifted[15:0];
        case (f3)
            3'b000:  return 32'(b);
            3'b001:  return 32'(h);
            3'b100:  return {24'd0, shifted[7:0]};
            3'b101:  return {16'd0, shifted[15:0]};
            default: return word;
        endcase
    endfunction

    // Replace only the addressed byte/half of the old word; every other bit
    // of the old word is preserved.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [31:0] mask;
        logic [31:0] ins;
        mask = (f3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {lane, 3'b000};
        ins  = data << {lane, 3'b000};
        return (old & ~mask) | (ins & mask);
    endfunction

    assign accept = req_valid & req_ready;
    assign fault  = is_fault(mem_rena, mem_wena, addr, funct3);

    // Control FSM. Outputs are registered alongside the state so they change
    // only on clock edges (or immediately on reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (fault) begin
                            state     <= ERR;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (mem_rena) begin
                            state <= RD;
                        end else if (funct3[1]) begin
                            // full-word store needs no read
                            state <= WR;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                RD, WR, RMW_WR: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end
                RMW_RD: begin
                    state <= RMW_WR;
                end
                RESP, ERR: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

    // Stage p0: request captured at the accepting edge
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0  <= addr[ADDR_W+1:0];
            wdata_p0 <= wdata;
            f3_p0    <= funct3;
            load_p0  <= mem_rena;
        end
    end

    assign word_idx  = addr_p0[ADDR_W+1:2];
    assign ram_re    = (state == RD) || (state == RMW_RD);
    assign ram_we    = (state == WR) || (state == RMW_WR);
    assign ram_wdata = (state == WR) ? wdata_p0
                                     : store_merge(ram_q, wdata_p0, addr_p0[1:0], f3_p0);

    // Stage p1: synchronous RAM access. Write enables derive from the state
    // register, so an asynchronous reset before the write edge drops the write.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[word_idx] <= ram_wdata;
        if (ram_re)
            ram_q <= mem[word_idx];
    end

    // Stage p2: response formatting; zero outside load responses
    assign rdata = ((state == RESP) && load_p0) ? load_extend(ram_q, addr_p0[1:0], f3_p0)
                                                : 32'd0;

endmodule
